prbs_checker: RTL and testbench

- Parameterised PRBS checker on the receive side of the serial link.
- Sits downstream of the transceiver RX user-clock output (rxdata, rxusrclk2 domain), in parallel with the frame aligner.
- Self-synchronises to a PRBS-7/15/23/31 stream of any word width and phase, then free-runs a seeded local LFSR.
- Reports per-bit errors, lock status and saturating bit/word counters for link BER measurement.

---
 rtl/prbs_checker.sv | 165 ++++++++++++++++
 tb/tb_prbs_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS-7/15/23/31 receive checker: self-synchronises to the incoming stream,
// then free-runs a local LFSR and reports per-bit errors, lock and BER counters.
module prbs_checker #(
  parameter int WORDWIDTH    = 32,
  parameter int PRBS_ORDER   = 7,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WORDWIDTH-1:0] i_din,
  input  logic                 i_din_valid,
  input  logic                 i_invert,
  input  logic                 i_clear_counters,
  output logic                 o_locked,
  output logic [WORDWIDTH-1:0] o_err_mask,
  output logic                 o_err_flag,
  output logic [CNT_WIDTH-1:0] o_bit_err_count,
  output logic [CNT_WIDTH-1:0] o_word_count
);

  localparam int N     = PRBS_ORDER;
  localparam int W     = WORDWIDTH;
  localparam int TAP_B = (PRBS_ORDER == 7)  ? 6  :
                         (PRBS_ORDER == 15) ? 14 :
                         (PRBS_ORDER == 23) ? 18 : 28;
  localparam int POPW  = $clog2(W + 1);
  localparam int SUMW  = CNT_WIDTH + POPW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (PRBS_ORDER != 7 && PRBS_ORDER != 15 && PRBS_ORDER != 23 && PRBS_ORDER != 31) begin : g_badOrder
    $error("prbs_checker: PRBS_ORDER must be 7, 15, 23 or 31");
  end
  if (WORDWIDTH < 8 || WORDWIDTH > 64) begin : g_badWidth
    $error("prbs_checker: WORDWIDTH must be 8..64");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255 || UNLOCK_COUNT < 1 || UNLOCK_COUNT > 255) begin : g_badCount
    $error("prbs_checker: LOCK_COUNT and UNLOCK_COUNT must be 1..255");
  end

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t               r_state;
  logic [N-1:0]         r_hist;
  logic [7:0]           r_cleanRun;
  logic [7:0]           r_errRun;
  logic                 r_locked;
  logic [W-1:0]         r_errMask;
  logic                 r_errFlag;
  logic [CNT_WIDTH-1:0] r_bitErrCount;
  logic [CNT_WIDTH-1:0] r_wordCount;

  logic [W-1:0]         w_d;
  logic [N+W-1:0]       w_sRx;
  logic [N+W-1:0]       w_sPr;
  logic [W-1:0]         w_expRx;
  logic [W-1:0]         w_pred;
  logic [W-1:0]         w_mask;
  logic [N-1:0]         w_histNext;
  logic [POPW-1:0]      w_popCount;
  logic [SUMW-1:0]      w_bitSum;
  logic [CNT_WIDTH-1:0] w_bitErrNext;
  logic [CNT_WIDTH-1:0] w_wordNext;

  assign w_d = i_din ^ {W{i_invert}};

  // Bit 0 of the history is the oldest; predicted bits feed back into the chain.
  always_comb begin
    w_sRx         = {w_d, r_hist};
    w_sPr         = '0;
    w_sPr[N-1:0]  = r_hist;
    w_expRx       = '0;
    w_pred        = '0;
    for (int i = 0; i < W; i++) begin
      w_expRx[i]  = w_sRx[i] ^ w_sRx[i+N-TAP_B];
      w_pred[i]   = w_sPr[i] ^ w_sPr[i+N-TAP_B];
      w_sPr[N+i]  = w_pred[i];
    end
  end

  assign w_mask     = w_d ^ ((r_state == LOCKED) ? w_pred : w_expRx);
  assign w_histNext = (r_state == LOCKED) ? w_sPr[N+W-1:W] : w_sRx[N+W-1:W];

  always_comb begin
    w_popCount = '0;
    for (int i = 0; i < W; i++) begin
      w_popCount = w_popCount + POPW'(w_mask[i]);
    end
  end

  assign w_bitSum     = SUMW'(r_bitErrCount) + SUMW'(w_popCount);
  assign w_bitErrNext = (w_bitSum > SUMW'(CNT_MAX)) ? CNT_MAX : w_bitSum[CNT_WIDTH-1:0];
  assign w_wordNext   = (r_wordCount == CNT_MAX) ? CNT_MAX : r_wordCount + CNT_WIDTH'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= SEARCH;
      r_hist        <= '0;
      r_cleanRun    <= '0;
      r_errRun      <= '0;
      r_locked      <= 1'b0;
      r_errMask     <= '0;
      r_errFlag     <= 1'b0;
      r_bitErrCount <= '0;
      r_wordCount   <= '0;
    end else begin
      if (i_clear_counters) begin
        r_bitErrCount <= '0;
        r_wordCount   <= '0;
      end else if (i_din_valid && r_state == LOCKED) begin
        r_bitErrCount <= w_bitErrNext;
        r_wordCount   <= w_wordNext;
      end

      if (i_din_valid) begin
        r_errMask <= w_mask;
        r_errFlag <= |w_mask;
        r_hist    <= w_histNext;
        case (r_state)
          SEARCH: begin
            // An all-zero word never counts, so an idle line cannot lock.
            if (w_mask == '0 && w_d != '0) begin
              if (r_cleanRun == 8'(LOCK_COUNT - 1)) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_cleanRun <= '0;
                r_errRun   <= '0;
              end else begin
                r_cleanRun <= r_cleanRun + 8'd1;
              end
            end else begin
              r_cleanRun <= '0;
            end
          end
          LOCKED: begin
            if (|w_mask) begin
              if (r_errRun == 8'(UNLOCK_COUNT - 1)) begin
                r_state    <= SEARCH;
                r_locked   <= 1'b0;
                r_errRun   <= '0;
                r_cleanRun <= '0;
              end else begin
                r_errRun <= r_errRun + 8'd1;
              end
            end else begin
              r_errRun <= '0;
            end
          end
          default: begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_locked        = r_locked;
  assign o_err_mask      = r_errMask;
  assign o_err_flag      = r_errFlag;
  assign o_bit_err_count = r_bitErrCount;
  assign o_word_count    = r_wordCount;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: four differently parameterised instances driven from
// bit-serial PRBS generators and checked every cycle against a bit-serial model.
module tb_prbs_checker;

  localparam int NDUT = 4;
  localparam int ORD  [NDUT] = '{7, 31, 15, 23};
  localparam int TAPB [NDUT] = '{6, 28, 14, 18};
  localparam int WID  [NDUT] = '{32, 16, 8, 24};
  localparam int CW   [NDUT] = '{32, 4, 32, 32};
  localparam int LOCKN   = 4;
  localparam int UNLOCKN = 4;

  logic clk = 1'b0;
  logic rstN;
  logic [63:0] din   [NDUT];
  logic        valid [NDUT];
  logic        inv   [NDUT];
  logic        clr   [NDUT];

  logic        lock0, flag0;
  logic [31:0] mask0, bc0, wc0;
  logic        lock1, flag1;
  logic [15:0] mask1;
  logic [3:0]  bc1, wc1;
  logic        lock2, flag2;
  logic [7:0]  mask2;
  logic [31:0] bc2, wc2;
  logic        lock3, flag3;
  logic [23:0] mask3;
  logic [31:0] bc3, wc3;

  int errors;
  int checks;

  logic [63:0] gs     [NDUT];
  logic [63:0] mHist  [NDUT];
  bit          mLocked[NDUT];
  int          mClean [NDUT];
  int          mErrRun[NDUT];
  logic [63:0] mMask  [NDUT];
  bit          mFlag  [NDUT];
  longint      mBits  [NDUT];
  longint      mWords [NDUT];

  always #5 clk = ~clk;

  prbs_checker #(.WORDWIDTH(32), .PRBS_ORDER(7), .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .CNT_WIDTH(32)) u_dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_din(din[0][31:0]), .i_din_valid(valid[0]), .i_invert(inv[0]),
    .i_clear_counters(clr[0]), .o_locked(lock0), .o_err_mask(mask0), .o_err_flag(flag0),
    .o_bit_err_count(bc0), .o_word_count(wc0));

  prbs_checker #(.WORDWIDTH(16), .PRBS_ORDER(31), .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .CNT_WIDTH(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_din(din[1][15:0]), .i_din_valid(valid[1]), .i_invert(inv[1]),
    .i_clear_counters(clr[1]), .o_locked(lock1), .o_err_mask(mask1), .o_err_flag(flag1),
    .o_bit_err_count(bc1), .o_word_count(wc1));

  prbs_checker #(.WORDWIDTH(8), .PRBS_ORDER(15), .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .CNT_WIDTH(32)) u_dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_din(din[2][7:0]), .i_din_valid(valid[2]), .i_invert(inv[2]),
    .i_clear_counters(clr[2]), .o_locked(lock2), .o_err_mask(mask2), .o_err_flag(flag2),
    .o_bit_err_count(bc2), .o_word_count(wc2));

  prbs_checker #(.WORDWIDTH(24), .PRBS_ORDER(23), .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .CNT_WIDTH(32)) u_dut3 (
    .i_clk(clk), .i_rst_n(rstN), .i_din(din[3][23:0]), .i_din_valid(valid[3]), .i_invert(inv[3]),
    .i_clear_counters(clr[3]), .o_locked(lock3), .o_err_mask(mask3), .o_err_flag(flag3),
    .o_bit_err_count(bc3), .o_word_count(wc3));

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transmitter: b[n] = b[n-ORDER] ^ b[n-TAPB], emitted LSB first.
  task automatic nextWord(input int k, output logic [63:0] w);
    int  n;
    int  b;
    logic nb;
    n = ORD[k];
    b = TAPB[k];
    w = '0;
    for (int i = 0; i < WID[k]; i++) begin
      nb = gs[k][0] ^ gs[k][n-b];
      w[i] = nb;
      gs[k] = gs[k] >> 1;
      gs[k][n-1] = nb;
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NDUT; k++) begin
      mHist[k] = '0; mLocked[k] = 0; mClean[k] = 0; mErrRun[k] = 0;
      mMask[k] = '0; mFlag[k] = 0; mBits[k] = 0; mWords[k] = 0;
    end
  endtask

  task automatic modelStep(input int k);
    logic [63:0] d, mask, h, wm;
    logic e, src;
    int n, b, w, pc;
    longint mx;
    n = ORD[k]; b = TAPB[k]; w = WID[k];
    wm = (64'h1 << w) - 64'h1;
    mx = (longint'(1) << CW[k]) - 1;
    mask = '0;
    pc = 0;
    if (valid[k]) begin
      d = (din[k] ^ {64{inv[k]}}) & wm;
      h = mHist[k];
      for (int i = 0; i < w; i++) begin
        e = h[0] ^ h[n-b];
        mask[i] = d[i] ^ e;
        if (mask[i]) pc++;
        src = mLocked[k] ? e : d[i];
        h = h >> 1;
        h[n-1] = src;
      end
      mHist[k] = h;
    end else begin
      d = '0;
    end
    if (clr[k]) begin
      mBits[k] = 0; mWords[k] = 0;
    end else if (valid[k] && mLocked[k]) begin
      mBits[k]  = (mBits[k] + pc > mx) ? mx : mBits[k] + pc;
      mWords[k] = (mWords[k] + 1 > mx) ? mx : mWords[k] + 1;
    end
    if (valid[k]) begin
      mMask[k] = mask;
      mFlag[k] = (mask != 0);
      if (!mLocked[k]) begin
        mClean[k] = (mask == 0 && d != 0) ? mClean[k] + 1 : 0;
        if (mClean[k] == LOCKN) begin
          mLocked[k] = 1; mClean[k] = 0; mErrRun[k] = 0;
        end
      end else begin
        mErrRun[k] = (mask != 0) ? mErrRun[k] + 1 : 0;
        if (mErrRun[k] == UNLOCKN) begin
          mLocked[k] = 0; mErrRun[k] = 0; mClean[k] = 0;
        end
      end
    end
  endtask

  task automatic compareAll();
    logic        ol, of;
    logic [63:0] om, ob, ow;
    for (int k = 0; k < NDUT; k++) begin
      case (k)
        0: begin ol = lock0; of = flag0; om = 64'(mask0); ob = 64'(bc0); ow = 64'(wc0); end
        1: begin ol = lock1; of = flag1; om = 64'(mask1); ob = 64'(bc1); ow = 64'(wc1); end
        2: begin ol = lock2; of = flag2; om = 64'(mask2); ob = 64'(bc2); ow = 64'(wc2); end
        default: begin ol = lock3; of = flag3; om = 64'(mask3); ob = 64'(bc3); ow = 64'(wc3); end
      endcase
      checkOutput($sformatf("k%0d_locked", k), 64'(ol), 64'(mLocked[k]));
      checkOutput($sformatf("k%0d_err_mask", k), om, mMask[k]);
      checkOutput($sformatf("k%0d_err_flag", k), 64'(of), 64'(mFlag[k]));
      checkOutput($sformatf("k%0d_bit_err_count", k), ob, 64'(mBits[k]));
      checkOutput($sformatf("k%0d_word_count", k), ow, 64'(mWords[k]));
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    if (!rstN) modelReset();
    else for (int k = 0; k < NDUT; k++) modelStep(k);
    #1;
    compareAll();
  endtask

  initial begin
    int nv;
    int p;
    logic [63:0] w;
    errors = 0;
    checks = 0;
    rstN = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      din[k] = '0; valid[k] = 1'b0; inv[k] = 1'b0; clr[k] = 1'b0;
      gs[k] = ({$urandom, $urandom} & ((64'h1 << ORD[k]) - 64'h1)) | 64'h1;
    end
    modelReset();

    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        din[k] = {$urandom, $urandom};
        valid[k] = 1'b1;
      end
      applyStimulus();
    end
    checkOutput("reset_locked0", 64'(lock0), 64'd0);
    checkOutput("reset_mask0", 64'(mask0), 64'd0);
    rstN = 1'b1;
    for (int k = 0; k < NDUT; k++) valid[k] = 1'b0;

    $display("[TB] PRBS-7 lock and 100 clean words");
    valid[0] = 1'b1;
    for (int c = 0; c < 20 && !lock0; c++) begin
      nextWord(0, w); din[0] = w;
      applyStimulus();
    end
    checkOutput("k0_lock_reached", 64'(lock0), 64'd1);
    checkOutput("k0_mask_at_lock", 64'(mask0), 64'd0);
    for (int c = 0; c < 100; c++) begin
      nextWord(0, w); din[0] = w;
      applyStimulus();
    end
    checkOutput("k0_words100", 64'(wc0), 64'd100);
    checkOutput("k0_biterr0", 64'(bc0), 64'd0);
    valid[0] = 1'b0;

    $display("[TB] PRBS-31 single flip, saturation and clear");
    valid[1] = 1'b1;
    for (int c = 0; c < 20 && !lock1; c++) begin
      nextWord(1, w); din[1] = w;
      applyStimulus();
    end
    checkOutput("k1_lock_reached", 64'(lock1), 64'd1);
    for (int c = 0; c < 3; c++) begin
      nextWord(1, w); din[1] = w;
      applyStimulus();
    end
    p = $urandom_range(15, 0);
    nextWord(1, w); din[1] = w ^ (64'h1 << p);
    applyStimulus();
    checkOutput("k1_flip_mask", 64'(mask1), 64'h1 << p);
    checkOutput("k1_flip_biterr", 64'(bc1), 64'd1);
    checkOutput("k1_flip_locked", 64'(lock1), 64'd1);
    nextWord(1, w); din[1] = w;
    applyStimulus();
    checkOutput("k1_after_flip_clean", 64'(mask1), 64'd0);
    for (int c = 0; c < 3; c++) begin
      nextWord(1, w); din[1] = w ^ (64'h1F << $urandom_range(11, 0));
      applyStimulus();
      nextWord(1, w); din[1] = w;
      applyStimulus();
    end
    checkOutput("k1_biterr_sat15", 64'(bc1), 64'd15);
    checkOutput("k1_burst_locked", 64'(lock1), 64'd1);
    clr[1] = 1'b1;
    nextWord(1, w); din[1] = w ^ 64'h3;
    applyStimulus();
    clr[1] = 1'b0;
    checkOutput("k1_clear_biterr", 64'(bc1), 64'd0);
    checkOutput("k1_clear_words", 64'(wc1), 64'd0);
    nextWord(1, w); din[1] = w ^ 64'h1;
    applyStimulus();
    valid[1] = 1'b0;

    $display("[TB] PRBS-15 inverted lock, invert drop, zero line");
    valid[2] = 1'b1;
    inv[2] = 1'b1;
    for (int c = 0; c < 20 && !lock2; c++) begin
      nextWord(2, w); din[2] = ~w;
      applyStimulus();
    end
    checkOutput("k2_inv_locked", 64'(lock2), 64'd1);
    inv[2] = 1'b0;
    for (int c = 0; c < UNLOCKN; c++) begin
      if (c == UNLOCKN - 1) checkOutput("k2_still_locked", 64'(lock2), 64'd1);
      nextWord(2, w); din[2] = ~w;
      applyStimulus();
      checkOutput("k2_all_bits_err", 64'(mask2), 64'hFF);
    end
    checkOutput("k2_unlocked", 64'(lock2), 64'd0);
    for (int c = 0; c < 30; c++) begin
      din[2] = '0;
      applyStimulus();
      checkOutput("k2_zero_nolock", 64'(lock2), 64'd0);
    end
    valid[2] = 1'b0;

    $display("[TB] PRBS-23 with alternating valid");
    for (int c = 0; c < 40 && !lock3; c++) begin
      valid[3] = (c % 2 == 0);
      if (valid[3]) begin nextWord(3, w); din[3] = w; end
      else din[3] = {$urandom, $urandom};
      applyStimulus();
    end
    checkOutput("k3_lock_reached", 64'(lock3), 64'd1);
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      valid[3] = (c % 2 == 1);
      if (valid[3]) begin nextWord(3, w); din[3] = w; nv++; end
      else din[3] = {$urandom, $urandom};
      applyStimulus();
    end
    checkOutput("k3_valid_words", 64'(wc3), 64'(nv));
    valid[3] = 1'b0;

    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midreset_locked0", 64'(lock0), 64'd0);
    checkOutput("midreset_words0", 64'(wc0), 64'd0);
    checkOutput("midreset_locked3", 64'(lock3), 64'd0);
    checkOutput("midreset_words3", 64'(wc3), 64'd0);
    applyStimulus();
    rstN = 1'b1;
    applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
